// File: rtl/enc_menu_pkg.sv
// Shared types and constants for the encoder parameter-menu controller.
package enc_menu_pkg;

    // Menu sequencing states
    typedef enum logic [1:0] {
        BROWSE = 2'd0,
        EDIT   = 2'd1,
        COMMIT = 2'd2
    } menu_state_e;

    // Classified push-button press codes (0 and 3 carry no meaning)
    localparam logic [1:0] PRESS_SHORT = 2'd1;
    localparam logic [1:0] PRESS_LONG  = 2'd2;

    // Encoder detent direction
    localparam logic DIR_CW  = 1'b1;
    localparam logic DIR_CCW = 1'b0;

endpackage

// File: rtl/enc_updn_cnt.sv
// Up/down counter with synchronous load; wraps or saturates at 0 and MAX.
// cnt_nxt exposes the value the counter will take at the next edge so that
// dependent logic can act on the same cycle the count updates.
module enc_updn_cnt
    import enc_menu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int MAX   = 255,
    parameter bit WRAP  = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             step,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] cnt,
    output logic [WIDTH-1:0] cnt_nxt
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    // Next count: load wins over step; ends either wrap or stick
    always_comb begin
        cnt_nxt = cnt;
        if (en) begin
            if (load) begin
                cnt_nxt = load_val;
            end else if (step) begin
                if (up) begin
                    if (cnt >= MAX_V) begin
                        cnt_nxt = WRAP ? '0 : MAX_V;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end else begin
                    if (cnt == '0) begin
                        cnt_nxt = WRAP ? MAX_V : '0;
                    end else begin
                        cnt_nxt = cnt - 1'b1;
                    end
                end
            end
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/enc_menu_ctrl.sv
// Rotary-encoder parameter menu: browse / edit / commit of a small register
// bank, with a one-cycle write strobe to the datapath configuration port.
// Optional build macro MENU_TIMEOUT_EN: abandons an idle edit after
// TIMEOUT_CYC cycles without an accepted step or press.
module enc_menu_ctrl
    import enc_menu_pkg::*;
#(
    parameter int NUM_PARAMS  = 4,
    parameter int VAL_W       = 8,
    parameter int TIMEOUT_CYC = 50000000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ena,
    input  logic                          step_valid,
    input  logic                          step_dir,
    input  logic                          press_valid,
    input  logic [1:0]                    press_type,
    output logic [$clog2(NUM_PARAMS)-1:0] sel_idx,
    output logic [VAL_W-1:0]              edit_val,
    output logic                          editing,
    output logic                          cfg_we,
    output logic [$clog2(NUM_PARAMS)-1:0] cfg_addr,
    output logic [VAL_W-1:0]              cfg_wdata,
    output logic [NUM_PARAMS*VAL_W-1:0]   param_flat,
    output logic                          timeout_evt
);

    localparam int SEL_W   = $clog2(NUM_PARAMS);
    localparam int VAL_MAX = (2 ** VAL_W) - 1;

    menu_state_e      state_q;
    menu_state_e      state_d;
    logic [VAL_W-1:0] param_q [NUM_PARAMS];

    logic             press_short;
    logic             press_long;
    logic             step_acc;
    logic             step_up;
    logic             tmo_fire;
    logic             commit_go;
    logic             sel_step;
    logic             val_step;
    logic             val_load;
    logic [SEL_W-1:0] sel_nxt;
    logic [VAL_W-1:0] val_nxt_unused;

    // Input decode: a meaningful press always shadows a same-cycle step
    always_comb begin
        press_short = press_valid && (press_type == PRESS_SHORT);
        press_long  = press_valid && (press_type == PRESS_LONG);
        step_acc    = step_valid && !press_short && !press_long;
        step_up     = 1'b0;
        case (step_dir)
            DIR_CW:  step_up = 1'b1;
            DIR_CCW: step_up = 1'b0;
        endcase
    end

    assign commit_go = (state_q == EDIT) && press_short;
    assign sel_step  = (state_q == BROWSE) && step_acc;
    assign val_step  = (state_q == EDIT) && step_acc;
    // In BROWSE the working value follows the register about to be selected;
    // a cancel in EDIT restores the committed value of the frozen selection.
    assign val_load  = (state_q == BROWSE) ||
                       ((state_q == EDIT) && (press_long || tmo_fire));

    enc_updn_cnt #(
        .WIDTH (SEL_W),
        .MAX   (NUM_PARAMS - 1),
        .WRAP  (1'b1)
    ) u_sel_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (ena),
        .step     (sel_step),
        .up       (step_up),
        .load     (1'b0),
        .load_val ('0),
        .cnt      (sel_idx),
        .cnt_nxt  (sel_nxt)
    );

    enc_updn_cnt #(
        .WIDTH (VAL_W),
        .MAX   (VAL_MAX),
        .WRAP  (1'b0)
    ) u_val_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (ena),
        .step     (val_step),
        .up       (step_up),
        .load     (val_load),
        .load_val (param_q[sel_nxt]),
        .cnt      (edit_val),
        .cnt_nxt  (val_nxt_unused)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BROWSE;
        end else if (ena) begin
            state_q <= state_d;
        end
    end

    // Next-state logic; COMMIT always lasts a single enabled cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            BROWSE: begin
                if (press_short) begin
                    state_d = EDIT;
                end
            end
            EDIT: begin
                if (press_short) begin
                    state_d = COMMIT;
                end else if (press_long || tmo_fire) begin
                    state_d = BROWSE;
                end
            end
            COMMIT: begin
                state_d = BROWSE;
            end
            default: begin
                state_d = BROWSE;
            end
        endcase
    end

    // Registered outputs and shadow registers; the bank and the strobe
    // update on the same edge so param_flat is current while cfg_we is high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            editing   <= 1'b0;
            cfg_we    <= 1'b0;
            cfg_addr  <= '0;
            cfg_wdata <= '0;
            for (int i = 0; i < NUM_PARAMS; i++) begin
                param_q[i] <= '0;
            end
        end else if (ena) begin
            editing <= (state_d == EDIT);
            cfg_we  <= commit_go;
            if (commit_go) begin
                cfg_addr         <= sel_idx;
                cfg_wdata        <= edit_val;
                param_q[sel_idx] <= edit_val;
            end
        end else begin
            cfg_we <= 1'b0;
        end
    end

    for (genvar i = 0; i < NUM_PARAMS; i++) begin : g_flat
        assign param_flat[i*VAL_W +: VAL_W] = param_q[i];
    end

`ifdef MENU_TIMEOUT_EN
    localparam int               TMO_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYC - 1);

    logic             input_acc;
    logic [TMO_W-1:0] tmo_q;

    assign input_acc = step_acc || press_short || press_long;
    assign tmo_fire  = (state_q == EDIT) && !input_acc && (tmo_q == '0);

    // Idle down-counter: reloaded outside EDIT and on any accepted input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q <= TMO_LOAD;
        end else if (ena) begin
            if ((state_q != EDIT) || input_acc) begin
                tmo_q <= TMO_LOAD;
            end else if (tmo_q != '0) begin
                tmo_q <= tmo_q - 1'b1;
            end
        end
    end

    // One-cycle notification when an edit is abandoned for inactivity
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_evt <= 1'b0;
        end else begin
            timeout_evt <= ena && tmo_fire;
        end
    end
`else
    logic unused_tmo;

    assign unused_tmo  = ^TIMEOUT_CYC;
    assign tmo_fire    = 1'b0;
    assign timeout_evt = 1'b0;
`endif

endmodule

// File: tb/tb_enc_menu_ctrl.sv
// Bench for enc_menu_ctrl: directed menu walk-through followed by random
// traffic, every cycle compared against a behavioural menu model.
module tb_enc_menu_ctrl;
    import enc_menu_pkg::*;

    localparam int NP = 4;
    localparam int VW = 8;
    localparam int TC = 20;
`ifdef MENU_TIMEOUT_EN
    localparam bit TMO_ON = 1'b1;
`else
    localparam bit TMO_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ena = 1'b0;
    logic          step_valid = 1'b0;
    logic          step_dir = 1'b0;
    logic          press_valid = 1'b0;
    logic [1:0]    press_type = 2'd0;
    logic [1:0]    sel_idx;
    logic [VW-1:0] edit_val;
    logic          editing;
    logic          cfg_we;
    logic [1:0]    cfg_addr;
    logic [VW-1:0] cfg_wdata;
    logic [NP*VW-1:0] param_flat;
    logic          timeout_evt;

    enc_menu_ctrl #(
        .NUM_PARAMS  (NP),
        .VAL_W       (VW),
        .TIMEOUT_CYC (TC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .step_valid  (step_valid),
        .step_dir    (step_dir),
        .press_valid (press_valid),
        .press_type  (press_type),
        .sel_idx     (sel_idx),
        .edit_val    (edit_val),
        .editing     (editing),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_wdata   (cfg_wdata),
        .param_flat  (param_flat),
        .timeout_evt (timeout_evt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    // Model: mode 0 = browsing, 1 = editing, 2 = commit cycle
    int m_sel, m_val, m_mode, m_idle, m_addr, m_wdata;
    int m_par [NP];
    bit m_we, m_tev;

    int exp_cw [5] = '{1, 2, 3, 0, 1};
    int exp_ccw [2] = '{0, 3};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_chk++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    task automatic model_reset();
        m_sel = 0; m_val = 0; m_mode = 0; m_idle = 0;
        m_addr = 0; m_wdata = 0; m_we = 0; m_tev = 0;
        for (int i = 0; i < NP; i++) m_par[i] = 0;
    endtask

    task automatic model_step(input bit sv, input bit sd, input bit pv, input bit [1:0] pt, input bit en);
        bit ps, pl, stp;
        ps  = pv && (pt == 2'd1);
        pl  = pv && (pt == 2'd2);
        stp = sv && !(ps || pl);
        m_we = 0;
        m_tev = 0;
        if (en) begin
            case (m_mode)
                0: begin
                    if (ps) begin
                        m_mode = 1;
                        m_idle = 0;
                    end else if (stp) begin
                        m_sel = (m_sel + (sd ? 1 : NP - 1)) % NP;
                    end
                    m_val = m_par[m_sel];
                end
                1: begin
                    if (ps) begin
                        m_mode = 2; m_we = 1;
                        m_addr = m_sel; m_wdata = m_val;
                        m_par[m_sel] = m_val;
                    end else if (pl) begin
                        m_mode = 0;
                        m_val = m_par[m_sel];
                    end else if (stp) begin
                        if (sd) m_val = (m_val == 255) ? 255 : m_val + 1;
                        else    m_val = (m_val == 0) ? 0 : m_val - 1;
                    end
`ifdef MENU_TIMEOUT_EN
                    else if (m_idle == TC - 1) begin
                        m_mode = 0;
                        m_val = m_par[m_sel];
                        m_tev = 1;
                    end
                    if (ps || pl || stp) m_idle = 0;
                    else if (!m_tev) m_idle++;
`endif
                end
                default: m_mode = 0;
            endcase
        end
    endtask

    task automatic check_all(input string tag);
        logic [NP*VW-1:0] ef;
        ef = '0;
        for (int i = 0; i < NP; i++) ef[i*VW +: VW] = m_par[i][VW-1:0];
        chk({tag, ".sel"},   sel_idx,     m_sel);
        chk({tag, ".val"},   edit_val,    m_val);
        chk({tag, ".edit"},  editing,     (m_mode == 1));
        chk({tag, ".we"},    cfg_we,      m_we);
        chk({tag, ".addr"},  cfg_addr,    m_addr);
        chk({tag, ".wdata"}, cfg_wdata,   m_wdata);
        chk({tag, ".flat"},  param_flat,  ef);
        chk({tag, ".tmo"},   timeout_evt, m_tev);
    endtask

    task automatic cycle(input string tag, input bit sv, input bit sd, input bit pv, input bit [1:0] pt, input bit en);
        step_valid = sv; step_dir = sd; press_valid = pv; press_type = pt; ena = en;
        @(posedge clk);
        #1;
        model_step(sv, sd, pv, pt, en);
        check_all(tag);
    endtask

    task automatic idle(input string tag);
        cycle(tag, 0, 0, 0, 2'd0, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [NP*VW-1:0] pf;
        int pulses;

        model_reset();
        rst_n = 1'b0; ena = 1'b1;
        #12;
        check_all("reset");
        chk("reset.flat0", param_flat, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            cycle("cw", 1, DIR_CW, 0, 2'd0, 1);
            chk("cw.seq", sel_idx, exp_cw[i]);
        end
        for (int i = 0; i < 2; i++) begin
            cycle("ccw", 1, DIR_CCW, 0, 2'd0, 1);
            chk("ccw.seq", sel_idx, exp_ccw[i]);
        end

        cycle("to2", 1, DIR_CCW, 0, 2'd0, 1);
        chk("to2.sel", sel_idx, 2);
        cycle("enter", 0, 0, 1, PRESS_SHORT, 1);
        chk("enter.editing", editing, 1);
        for (int i = 0; i < 3; i++) begin
            cycle("inc", 1, DIR_CW, 0, 2'd0, 1);
            chk("inc.val", edit_val, i + 1);
        end
        cycle("commit", 0, 0, 1, PRESS_SHORT, 1);
        pf = param_flat;
        chk("commit.we", cfg_we, 1);
        chk("commit.addr", cfg_addr, 2);
        chk("commit.wdata", cfg_wdata, 3);
        chk("commit.p2", pf[23:16], 3);
        idle("post");
        chk("post.we", cfg_we, 0);
        chk("post.editing", editing, 0);

        cycle("to1", 1, DIR_CCW, 0, 2'd0, 1);
        cycle("to0", 1, DIR_CCW, 0, 2'd0, 1);
        cycle("e0", 0, 0, 1, PRESS_SHORT, 1);
        cycle("e0dn", 1, DIR_CCW, 0, 2'd0, 1);
        chk("sat0.val", edit_val, 0);
        cycle("e0x", 0, 0, 1, PRESS_LONG, 1);

        cycle("sel1", 1, DIR_CW, 0, 2'd0, 1);
        cycle("e1", 0, 0, 1, PRESS_SHORT, 1);
        repeat (254) cycle("pre", 1, DIR_CW, 0, 2'd0, 1);
        cycle("pre.c", 0, 0, 1, PRESS_SHORT, 1);
        idle("pre.i");
        cycle("e1b", 0, 0, 1, PRESS_SHORT, 1);
        chk("e1b.val", edit_val, 254);
        repeat (3) cycle("up", 1, DIR_CW, 0, 2'd0, 1);
        chk("sat255.val", edit_val, 255);
        cycle("e1x", 0, 0, 1, PRESS_LONG, 1);
        chk("e1x.val", edit_val, 254);

        cycle("sel2", 1, DIR_CW, 0, 2'd0, 1);
        cycle("e2", 0, 0, 1, PRESS_SHORT, 1);
        repeat (4) cycle("e2up", 1, DIR_CW, 0, 2'd0, 1);
        chk("e2up.val", edit_val, 7);
        cycle("cancel", 0, 0, 1, PRESS_LONG, 1);
        pf = param_flat;
        chk("cancel.editing", editing, 0);
        chk("cancel.val", edit_val, 3);
        chk("cancel.we", cfg_we, 0);
        chk("cancel.p2", pf[23:16], 3);
        idle("cancel.i");
        chk("cancel.we2", cfg_we, 0);

        cycle("both", 1, DIR_CW, 1, PRESS_SHORT, 1);
        chk("both.editing", editing, 1);
        chk("both.sel", sel_idx, 2);
        repeat (10) begin
            cycle("frz", 1, DIR_CW, 1, PRESS_SHORT, 0);
            chk("frz.val", edit_val, 3);
        end
        cycle("frz.x", 0, 0, 1, PRESS_LONG, 1);
        cycle("bad0", 1, DIR_CW, 1, 2'd0, 1);
        cycle("bad3", 0, 0, 1, 2'd3, 1);
        chk("bad3.editing", editing, 0);

        cycle("rst.e", 0, 0, 1, PRESS_SHORT, 1);
        cycle("rst.s", 1, DIR_CW, 0, 2'd0, 1);
        cycle("rst.c", 0, 0, 1, PRESS_SHORT, 1);
        chk("rst.c.we", cfg_we, 1);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("rst.mid");
        @(negedge clk);
        rst_n = 1'b1;

        cycle("t.e", 0, 0, 1, PRESS_SHORT, 1);
        pulses = 0;
        repeat (25) begin
            idle("t.idle");
            if (timeout_evt === 1'b1) pulses++;
        end
        chk("t.pulses", pulses, TMO_ON ? 1 : 0);
        chk("t.editing", editing, TMO_ON ? 0 : 1);
        if (!TMO_ON) cycle("t.x", 0, 0, 1, PRESS_LONG, 1);

        cycle("t2.e", 0, 0, 1, PRESS_SHORT, 1);
        for (int k = 0; k < 4; k++) begin
            repeat (14) idle("t2.idle");
            cycle("t2.step", 1, DIR_CW, 0, 2'd0, 1);
        end
        chk("t2.editing", editing, 1);
        chk("t2.val", edit_val, 4);
        cycle("t2.x", 0, 0, 1, PRESS_LONG, 1);

        repeat (800) begin
            bit sv, sd, pv, en;
            bit [1:0] pt;
            sv = 1'($urandom_range(0, 1));
            sd = 1'($urandom_range(0, 1));
            pv = ($urandom_range(0, 5) == 0);
            pt = 2'($urandom_range(0, 3));
            en = ($urandom_range(0, 9) != 0);
            cycle("rand", sv, sd, pv, pt, en);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
